pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 28, width of all cycle counters and measurement outputs.
REQ-002 Parameter TIMEOUT, default 48_000_000, idle cycles without an edge before declaring stuck (must satisfy 2 <= TIMEOUT <= 2^CNT_W-1).
REQ-003 int_osc  input  1  sole clock; all flops on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pwm_in  input  1  asynchronous PWM waveform to measure.
REQ-006 meas_ready  input  1  consumer accepts measurement when high with meas_valid.
REQ-007 meas_valid  output  1  period/high_time hold a completed measurement.
REQ-008 period  output  CNT_W  cycles between consecutive detected rising edges.
REQ-009 high_time  output  CNT_W  cycles from detected rise to detected fall within that period.
REQ-010 overrun  output  1  sticky: a measurement was dropped while meas_valid was held.
REQ-011 stuck_high / stuck_low  output  1 each  input held at that level for TIMEOUT cycles.

Function
REQ-012 pwm_in SHALL pass a 2-flop synchronizer; rise/fall SHALL be detected against a third registered copy (input edge to detect pulse: 3 cycles).
REQ-013 FSM states: IDLE, HIGH, LOW; reset state IDLE.
REQ-014 IDLE: falls ignored; rise -> HIGH, cnt <= 1.
REQ-015 HIGH: cnt increments each cycle; fall -> LOW, high_cap <= cnt, cnt continues incrementing.
REQ-016 LOW: cnt increments; rise -> HIGH, cnt <= 1, measurement {period=cnt, high_time=high_cap} completes.
REQ-017 Completed measurement SHALL load period/high_time and set meas_valid on the next clock edge (1-cycle latency from rise detect).
REQ-018 Handshake: meas_valid && meas_ready in a cycle clears meas_valid next cycle; outputs stable while meas_valid && !meas_ready.
REQ-019 Completion while meas_valid && !meas_ready: data SHALL NOT change; overrun <= 1.
REQ-020 Completion in the same cycle as a handshake: new data loaded, meas_valid stays 1, overrun unchanged.
REQ-021 overrun SHALL clear on the cycle after a handshake not coinciding with a drop.
REQ-022 cnt SHALL saturate at TIMEOUT; reaching TIMEOUT in HIGH -> IDLE, stuck_high <= 1; in LOW -> IDLE, stuck_low <= 1; no measurement produced.
REQ-023 stuck_high/stuck_low SHALL clear on the next detected edge of either polarity.
REQ-024 IDLE with synchronized input high after timeout: wait for a fall then a rise; first rise re-enters HIGH.

Reset
REQ-025 rst SHALL asynchronously force: state IDLE, cnt=0, high_cap=0, period=0, high_time=0, meas_valid=0, overrun=0, stuck_high=0, stuck_low=0, synchronizer flops=0.
REQ-026 rst mid-measurement SHALL discard the partial measurement; first post-reset measurement requires a fresh rise.

Structure
REQ-027 Shared package pwm_capture_pkg SHALL hold the FSM state encoding and the default CNT_W/TIMEOUT constants.
REQ-028 Synchronizer plus edge detector SHALL be a sub-module edge_sync (outputs level, rise, fall).
REQ-029 Target RTL size 120-400 lines, no vendor primitives.

Verification (TIMEOUT=1000, CNT_W=28 unless stated)
REQ-030 Steady PWM period 100, high 25, meas_ready=1 -> each valid shows period=100, high_time=25; first measurement only after second rise.
REQ-031 meas_ready=0 across 3 periods of 100/40 then ready=1 -> first captured values held throughout, overrun=1, cleared after the next unstalled handshake.
REQ-032 pwm_in held high 1500 cycles after a rise -> stuck_high=1 exactly TIMEOUT cycles after rise detect, no meas_valid, FSM IDLE; next fall clears stuck_high.
REQ-033 pwm_in already high at reset release, falls after 50 cycles -> fall ignored, no measurement until two rises observed.
REQ-034 rst asserted 30 cycles into HIGH -> all outputs 0 immediately (asynchronous); after release, period 80/high 20 measured correctly.
REQ-035 Completion coincident with handshake (ready pulsed on completion cycle) -> meas_valid stays 1, new values present, overrun=0.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM period/high-time capture block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam int CNT_W_DEF   = 28;
    localparam int TIMEOUT_DEF = 48_000_000;

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement result channel: valid/ready handshake carrying period and high time.
// Latency: n/a (wires only).
// Backpressure: producer holds data stable while meas_valid && !meas_ready.
// Ports: meas_valid, period, high_time (producer -> consumer); meas_ready (consumer -> producer).
interface pwm_capture_if
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             meas_valid;
    logic             meas_ready;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;

    modport master (output meas_valid, output period, output high_time, input meas_ready);
    modport slave  (input meas_valid, input period, input high_time, output meas_ready);
endinterface

// File: rtl/pwm_capture_edge_sync.sv
// Two-flop synchronizer plus a third registered copy for rise/fall detection.
// Latency: input change to detect pulse is 3 cycles; level is 2 cycles behind din.
// Backpressure: none; rise/fall are single-cycle pulses.
// Ports: clk, rst (async, active-high), din (async input), level, rise, fall.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic       s1;
    logic       s2;
    logic       s3;
    logic [2:0] arm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s3  <= 1'b0;
            arm <= 3'b000;
        end else begin
            s1  <= din;
            s2  <= s1;
            s3  <= s2;
            arm <= {arm[1:0], 1'b1};
        end
    end

    // The chain clears to 0 on reset, so an input already high at release
    // would look like a rise while it fills. Edges are only trusted once s3
    // holds a genuinely sampled value (three edges after release).
    assign level = s2;
    assign rise  = arm[2] &  s2 & ~s3;
    assign fall  = arm[2] & ~s2 &  s3;
endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time in int_osc cycles, flags stuck-high/low inputs.
// Latency: result valid 1 cycle after the closing rise is detected (4 cycles after pwm_in edge).
// Backpressure: results held while meas_valid && !meas_ready; new results then dropped and overrun set.
// Ports: int_osc (clock), rst (async, active-high), pwm_in (async), meas (result channel),
//        overrun (sticky drop flag), stuck_high / stuck_low (timeout flags).
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 int_osc,
    input  logic                 rst,
    input  logic                 pwm_in,
    pwm_capture_if.master        meas,
    output logic                 overrun,
    output logic                 stuck_high,
    output logic                 stuck_low
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             level;
    logic             rise;
    logic             fall;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] high_cap, high_cap_nxt;
    logic             complete;
    logic             timeout_hit;

    logic             meas_valid_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             handshake;

    edge_sync u_edge_sync (
        .clk   (int_osc),
        .rst   (rst),
        .din   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            high_cap <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            high_cap <= high_cap_nxt;
        end
    end

    // The timeout fires on the edge where cnt would reach TIMEOUT, so the stuck
    // flag appears exactly TIMEOUT cycles after the rise that started the count.
    // A detected edge always wins over the timeout in the same cycle.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        high_cap_nxt = high_cap;
        complete     = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_nxt    = ST_LOW;
                    high_cap_nxt = cnt;
                    cnt_nxt      = cnt + CNT_ONE;
                end else if (cnt >= CNT_LIM) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = CNT_MAX;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = CNT_ONE;
                    complete  = 1'b1;
                end else if (cnt >= CNT_LIM) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = CNT_MAX;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // With no edge pending the synchronized level is the rail the input is
    // sitting on, which tells the timeout which stuck flag to raise.
    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else if (rise || fall) begin
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
        end else if (timeout_hit) begin
            stuck_high <= level;
            stuck_low  <= ~level;
        end
    end

    assign handshake = meas_valid_q && meas.meas_ready;

    // A completion that coincides with a handshake replaces the data in place
    // and leaves overrun alone; a completion against a stalled consumer is dropped.
    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            meas_valid_q <= 1'b0;
            period_q     <= '0;
            high_time_q  <= '0;
            overrun      <= 1'b0;
        end else if (complete) begin
            if (!meas_valid_q || meas.meas_ready) begin
                meas_valid_q <= 1'b1;
                period_q     <= cnt;
                high_time_q  <= high_cap;
            end else begin
                overrun <= 1'b1;
            end
        end else if (handshake) begin
            meas_valid_q <= 1'b0;
            overrun      <= 1'b0;
        end
    end

    assign meas.meas_valid = meas_valid_q;
    assign meas.period     = period_q;
    assign meas.high_time  = high_time_q;
endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;
    localparam int CW = 28;
    localparam int TO = 1000;

    logic int_osc = 1'b0;
    logic rst;
    logic pwm_in;
    logic overrun;
    logic stuck_high;
    logic stuck_low;

    pwm_capture_if #(.CNT_W(CW)) meas ();

    pwm_capture #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .int_osc    (int_osc),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .meas       (meas),
        .overrun    (overrun),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    always #5 int_osc = ~int_osc;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    logic [CW-1:0] qp[$];
    logic [CW-1:0] qh[$];

    // Record every accepted measurement and every cycle meas_valid is high.
    always @(negedge int_osc) begin
        if (!rst) begin
            if (meas.meas_valid) vcnt++;
            if (meas.meas_valid && meas.meas_ready) begin
                qp.push_back(meas.period);
                qh.push_back(meas.high_time);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge int_osc);
            #1;
        end
    endtask

    task automatic gen(input int p, input int h);
        pwm_in = 1'b1;
        step(h);
        pwm_in = 1'b0;
        step(p - h);
    endtask

    task automatic do_reset(input logic pwm_lvl, input logic rdy);
        rst             = 1'b1;
        pwm_in          = pwm_lvl;
        meas.meas_ready = rdy;
        step(3);
        rst = 1'b0;
        qp.delete();
        qh.delete();
        vcnt = 0;
    endtask

    function automatic logic [CW-1:0] qget(input int which, input int i);
        if (which == 0) return (qp.size() > i) ? qp[i] : '1;
        else            return (qh.size() > i) ? qh[i] : '1;
    endfunction

    initial begin
        rst             = 1'b1;
        pwm_in          = 1'b0;
        meas.meas_ready = 1'b1;
        step(2);
        chk("rst_valid",     meas.meas_valid, 0);
        chk("rst_period",    meas.period, 0);
        chk("rst_high_time", meas.high_time, 0);
        chk("rst_overrun",   overrun, 0);
        chk("rst_stuck",     {stuck_high, stuck_low}, 0);

        // Steady 100/25 with ready high.
        do_reset(1'b0, 1'b1);
        step(5);
        gen(100, 25);
        chk("t1_none_before_rise2", qp.size(), 0);
        repeat (3) gen(100, 25);
        step(5);
        chk("t1_count", qp.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_period%0d", i), qget(0, i), 100);
            chk($sformatf("t1_high%0d", i),   qget(1, i), 25);
        end

        // Stalled consumer: first result held, later ones dropped.
        do_reset(1'b0, 1'b0);
        step(5);
        gen(100, 40);
        gen(100, 40);
        gen(90, 30);
        pwm_in = 1'b1;
        step(6);
        chk("t2_valid_held",  meas.meas_valid, 1);
        chk("t2_period_held", meas.period, 100);
        chk("t2_high_held",   meas.high_time, 40);
        chk("t2_overrun_set", overrun, 1);
        meas.meas_ready = 1'b1;
        step(2);
        chk("t2_valid_clr",   meas.meas_valid, 0);
        chk("t2_overrun_clr", overrun, 0);
        chk("t2_hs_period",   qget(0, 0), 100);

        // Stuck high after a rise.
        do_reset(1'b0, 1'b1);
        step(5);
        pwm_in = 1'b1;
        step(TO + 1);
        @(negedge int_osc);
        chk("t3_stuck_early", stuck_high, 0);
        @(posedge int_osc);
        #1;
        @(negedge int_osc);
        chk("t3_stuck_at_to", stuck_high, 1);
        chk("t3_no_valid",    vcnt, 0);
        step(1500 - TO - 3);
        chk("t3_stuck_hold",  {stuck_high, stuck_low}, 2'b10);
        pwm_in = 1'b0;
        step(6);
        chk("t3_stuck_clr",   stuck_high, 0);
        gen(60, 20);
        pwm_in = 1'b1;
        step(6);
        chk("t3_rearm_count", qp.size(), 1);
        chk("t3_rearm_period", qget(0, 0), 60);
        chk("t3_rearm_high",   qget(1, 0), 20);

        // Input high at reset release; the first fall is ignored.
        do_reset(1'b1, 1'b1);
        step(50);
        pwm_in = 1'b0;
        step(30);
        gen(70, 30);
        chk("t4_none_before_rise2", qp.size(), 0);
        pwm_in = 1'b1;
        step(6);
        chk("t4_count",  qp.size(), 1);
        chk("t4_period", qget(0, 0), 70);
        chk("t4_high",   qget(1, 0), 30);

        // Asynchronous reset mid-measurement.
        do_reset(1'b0, 1'b0);
        step(5);
        repeat (3) gen(100, 25);
        pwm_in = 1'b1;
        step(30);
        chk("t5_pre_valid",   meas.meas_valid, 1);
        chk("t5_pre_overrun", overrun, 1);
        @(posedge int_osc);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_outs", {meas.meas_valid, overrun, stuck_high, stuck_low}, 0);
        chk("t5_async_period", meas.period, 0);
        chk("t5_async_high",   meas.high_time, 0);
        step(2);
        rst = 1'b0;
        meas.meas_ready = 1'b1;
        qp.delete();
        qh.delete();
        step(5);
        pwm_in = 1'b0;
        step(20);
        gen(80, 20);
        gen(80, 20);
        pwm_in = 1'b1;
        step(6);
        chk("t5_count", qp.size(), 2);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t5_period%0d", i), qget(0, i), 80);
            chk($sformatf("t5_high%0d", i),   qget(1, i), 20);
        end

        // Completion in the same cycle as a handshake.
        do_reset(1'b0, 1'b0);
        step(5);
        gen(100, 25);
        gen(60, 20);
        chk("t6_pre_period", meas.period, 100);
        pwm_in = 1'b1;
        step(2);
        meas.meas_ready = 1'b1;
        step(1);
        meas.meas_ready = 1'b0;
        @(negedge int_osc);
        chk("t6_valid",   meas.meas_valid, 1);
        chk("t6_period",  meas.period, 60);
        chk("t6_high",    meas.high_time, 20);
        chk("t6_overrun", overrun, 0);
        step(3);
        chk("t6_valid_hold", meas.meas_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
